// File: rtl/multdiv_seq.sv
// Sequential signed multiply/divide unit.
// Multiply: radix-2 Booth, 32 iterations into a 65-bit product register.
// Divide: non-restoring on operand magnitudes, sign fix-up at completion;
// the divider datapath is built only when MULTDIV_DIV_EN is defined,
// otherwise a divide start completes at once with result 0 and exception set.
module multdiv_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam int unsigned W    = 32;
  localparam int unsigned PW   = 2 * W + 1;
  localparam int unsigned CW   = 6;
  localparam int unsigned ITER = 32;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   count, count_n;
  logic [W-1:0]    mcand, mcand_n;
  logic [PW-1:0]   prod, prod_n;
  logic            op_div, op_div_n;
  logic [W-1:0]    result_n;
  logic            exc_n, rdy_n, busy_n;
  logic            start;
  logic [W:0]      acc, madd, sum;

`ifdef MULTDIV_DIV_EN
  logic [W:0]      rem, rem_n, rem_sh, diff;
  logic [W-1:0]    quo, quo_n;
  logic [W-1:0]    dvsr, dvsr_n;
  logic            neg_q, neg_q_n;
  logic            div_zero, div_zero_n;
  logic            div_ovf, div_ovf_n;
  logic [W-1:0]    a_mag, b_mag;
`endif

  assign start = ctrl_MULT | ctrl_DIV;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state, datapath step and output decode
  always_comb begin
    state_n  = state;
    count_n  = count;
    mcand_n  = mcand;
    prod_n   = prod;
    op_div_n = op_div;
    result_n = data_result;
    exc_n    = data_exception;
    rdy_n    = 1'b0;

    // Booth step: 33-bit sum keeps the true sign when the add overflows 32 bits
    acc  = {prod[PW-1], prod[PW-1:W+1]};
    madd = {mcand[W-1], mcand};
    case (prod[1:0])
      2'b01:   sum = acc + madd;
      2'b10:   sum = acc - madd;
      default: sum = acc;
    endcase

`ifdef MULTDIV_DIV_EN
    rem_n      = rem;
    quo_n      = quo;
    dvsr_n     = dvsr;
    neg_q_n    = neg_q;
    div_zero_n = div_zero;
    div_ovf_n  = div_ovf;
    rem_sh     = {rem[W-1:0], quo[W-1]};
    diff       = rem[W] ? (rem_sh + {1'b0, dvsr}) : (rem_sh - {1'b0, dvsr});
    a_mag      = data_operandA[W-1] ? (~data_operandA + W'(1)) : data_operandA;
    b_mag      = data_operandB[W-1] ? (~data_operandB + W'(1)) : data_operandB;
`endif

    case (state)
      MULT: begin
        prod_n  = {sum, prod[W:1]};
        count_n = count + CW'(1);
        if (count == CW'(ITER - 1)) state_n = DONE;
      end
      DIV: begin
`ifdef MULTDIV_DIV_EN
        rem_n   = diff;
        quo_n   = {quo[W-2:0], ~diff[W]};
        count_n = count + CW'(1);
        if (count == CW'(ITER - 1)) state_n = DONE;
`else
        state_n = IDLE;
`endif
      end
      DONE: begin
        state_n = IDLE;
        rdy_n   = 1'b1;
        if (op_div) begin
`ifdef MULTDIV_DIV_EN
          if (div_zero) begin
            result_n = '0;
            exc_n    = 1'b1;
          end else if (div_ovf) begin
            result_n = {1'b1, {(W-1){1'b0}}};
            exc_n    = 1'b1;
          end else begin
            result_n = neg_q ? (~quo + W'(1)) : quo;
            exc_n    = 1'b0;
          end
`else
          result_n = '0;
          exc_n    = 1'b1;
`endif
        end else begin
          result_n = prod[W:1];
          exc_n    = (prod[PW-1:W+1] != {W{prod[W]}});
        end
      end
      default: ;
    endcase

    // A start pulse aborts whatever is in flight and restarts
    if (start) begin
      count_n  = '0;
      mcand_n  = data_operandA;
      prod_n   = {{W{1'b0}}, data_operandB, 1'b0};
      op_div_n = ~ctrl_MULT;
      result_n = '0;
      exc_n    = 1'b0;
      rdy_n    = 1'b0;
      if (ctrl_MULT) begin
        state_n = MULT;
      end else begin
`ifdef MULTDIV_DIV_EN
        state_n    = DIV;
        rem_n      = '0;
        quo_n      = a_mag;
        dvsr_n     = b_mag;
        neg_q_n    = data_operandA[W-1] ^ data_operandB[W-1];
        div_zero_n = (data_operandB == '0);
        div_ovf_n  = (data_operandA == {1'b1, {(W-1){1'b0}}}) && (data_operandB == {W{1'b1}});
`else
        state_n = DONE;
`endif
      end
    end

    busy_n = (state_n != IDLE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count          <= '0;
      mcand          <= '0;
      prod           <= '0;
      op_div         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      count          <= count_n;
      mcand          <= mcand_n;
      prod           <= prod_n;
      op_div         <= op_div_n;
      data_result    <= result_n;
      data_exception <= exc_n;
      data_resultRDY <= rdy_n;
      busy           <= busy_n;
    end
  end

`ifdef MULTDIV_DIV_EN
  // Divider registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
    end else begin
      rem      <= rem_n;
      quo      <= quo_n;
      dvsr     <= dvsr_n;
      neg_q    <= neg_q_n;
      div_zero <= div_zero_n;
      div_ovf  <= div_ovf_n;
    end
  end
`endif

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port data_operandA, input, 32 bits: signed multiplicand or dividend.
REQ-004 SHALL have port data_operandB, input, 32 bits: signed multiplier or divisor.
REQ-005 SHALL have port ctrl_MULT, input, 1 bit: start-multiply pulse.
REQ-006 SHALL have port ctrl_DIV, input, 1 bit: start-divide pulse.
REQ-007 SHALL have port data_result, output, 32 bits: signed result.
REQ-008 SHALL have port data_exception, output, 1 bit: overflow or divide-by-zero flag.
REQ-009 SHALL have port data_resultRDY, output, 1 bit: one-cycle completion pulse; this is the decode stall unit's multDivReady input.
REQ-010 SHALL have port busy, output, 1 bit: high while an operation is in flight.

Function
REQ-011 SHALL implement states IDLE, MULT, DIV and DONE.
REQ-012 SHALL, when ctrl_MULT or ctrl_DIV is high at an edge (the start edge), latch both operands, clear the iteration counter, and enter MULT or DIV.
REQ-013 SHALL give ctrl_MULT priority when both start pulses are high at the same edge.
REQ-014 SHALL treat a start pulse in any state, busy included, as an abort of the current operation followed by a restart with the new operands; the aborted operation produces no data_resultRDY pulse.
REQ-015 SHALL compute multiply with radix-2 Booth recoding, one iteration per cycle, 32 iterations, into a 65-bit product register.
REQ-016 SHALL compute divide with non-restoring division on operand magnitudes, 32 iterations, with signs fixed up afterwards.
REQ-017 SHALL truncate the divide quotient toward zero and SHALL not output the remainder.
REQ-018 SHALL leave MULT/DIV for DONE at the 32nd iteration edge.
REQ-019 SHALL, in DONE, drive data_resultRDY high for exactly one cycle, then return to IDLE; the pulse is high in the cycle beginning 33 edges after the start edge.
REQ-020 SHALL hold busy high from the start edge until the DONE cycle, inclusive.
REQ-021 SHALL, for multiply, drive data_result with product bits [31:0].
REQ-022 SHALL set data_exception for multiply when product bits [63:32] are not all equal to product bit 31.
REQ-023 SHALL, for a zero divisor, drive data_result = 0x00000000 and data_exception = 1, with normal latency.
REQ-024 SHALL, for 0x80000000 / 0xFFFFFFFF, drive data_result = 0x80000000 and data_exception = 1.
REQ-025 SHALL hold data_result and data_exception stable from DONE until the next start edge.
REQ-026 SHALL clear data_result and data_exception to 0 at the next start edge.
REQ-027 SHALL not let the operand inputs affect an in-flight operation after the start edge.

Reset
REQ-028 SHALL, while reset is low, immediately force state IDLE, counter 0, and data_result, data_exception, data_resultRDY and busy to 0, independent of clock.
REQ-029 SHALL discard an operation interrupted by reset, produce no data_resultRDY pulse for it, and ignore start pulses while reset is low.

Configuration
REQ-030 SHALL build the divider datapath only when macro MULTDIV_DIV_EN is defined.
REQ-031 SHALL, with MULTDIV_DIV_EN undefined, treat ctrl_DIV as a start that goes directly to DONE.
REQ-032 SHALL, in that case, pulse data_resultRDY in the cycle after the start edge with data_result = 0 and data_exception = 1; multiply is unchanged.

Verification
REQ-033 SHALL cover: MULT with A=7, B=0xFFFFFFFD -> data_result=0xFFFFFFEB, data_exception=0, data_resultRDY high for one cycle, 33 edges after start.
REQ-034 SHALL cover: MULT with A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1.
REQ-035 SHALL cover: DIV with A=0xFFFFFF9C (-100), B=7 -> data_result=0xFFFFFFF2 (-14), data_exception=0; and DIV 5/0 -> data_result=0, data_exception=1.
REQ-036 SHALL cover: MULT 3*4 started, then DIV 20/5 started 10 cycles later -> a single data_resultRDY pulse 33 edges after the second start, data_result=4.
REQ-037 SHALL cover: reset driven low mid-edge 15 cycles into MULT 9*9 -> outputs 0 immediately, no data_resultRDY pulse; a MULT 9*9 after release -> data_result=81.
REQ-038 SHALL cover, in a build without MULTDIV_DIV_EN: DIV 20/5 -> data_resultRDY in the cycle after start, data_result=0, data_exception=1.
